mp3_pc_ram_reader: RTL and testbench
====================================

# mp3_pc_ram_reader

Avalon-MM read master that streams a contiguous block of 32-bit words out of the 4096-word on-chip program/data RAM into an Avalon-ST source. It drives the RAM's slave port with address/read only, using the RAM's fixed one-cycle read latency and no waitrequest. Each word passes through a small show-ahead FIFO so that a downstream MP3 bitstream consumer can apply backpressure. Software starts a transfer with an address and a word count and sees busy/done status.

## Interface
- FIFO_DEPTH, 4: output FIFO depth in words; power of two, 2..16.
- clk  in  1  sole clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  12  first RAM word address.
- word_count  in  13  words to transfer, 0..4096.
- abort  in  1  cancel the current transfer; flushes the FIFO.
- busy  out  1  high from the cycle after an accepted start until the transfer finishes or aborts.
- done  out  1  one-cycle pulse when a transfer completes; no pulse on abort.
- avm_address  out  12  RAM word address.
- avm_read  out  1  read strobe; readdata is valid exactly 1 cycle later.
- avm_readdata  in  32  RAM read data.
- src_data  out  32  stream word.
- src_valid  out  1  stream valid.
- src_ready  in  1  stream ready; a beat transfers on valid & ready.
- src_last  out  1  high with the final word of a transfer.

## Operation
- States:
  - IDLE: accepts start. If word_count==0, pulse done the next cycle and stay in IDLE. Otherwise latch address and count, then go to READ.
  - READ: issue reads. Leave for DRAIN in the cycle after the last read issues.
  - DRAIN: wait until the FIFO is empty and no read is outstanding, then pulse done and go to IDLE.
- Issue rule: assert avm_read when issued < count and (fifo_count − pop + outstanding) < FIFO_DEPTH.
  - pop is the current-cycle src handshake; outstanding is 0 or 1.
  - avm_address advances by 1 per issued read, modulo 4096: 4095 wraps to 0.
- Return: when the read-delayed strobe is set, capture avm_readdata into the FIFO. The FIFO never overflows, by the issue rule.
- src_last: tagged on the word whose return index equals count−1.
- start while busy: ignored.
- abort: in any state, the next cycle is IDLE, the FIFO is emptied, src_valid=0, and any in-flight return is discarded; busy=0, no done pulse. abort takes priority over a simultaneous start.
- Reset: busy=0, done=0, avm_read=0, avm_address=0, src_valid=0, src_data=0, src_last=0. FIFO empty, state IDLE.

## Timing
- start accepted at edge E0: busy=1 and avm_read=1 with avm_address=start_addr in cycle E0+1.
- Data for that read is written to the FIFO at E0+2. src_valid=1 from E0+3 (show-ahead).
- With src_ready held high: one word per cycle sustained; last word at E0+2+N; done pulses at E0+3+N, busy drops the same cycle.
- src_ready low: reads stall once occupancy plus outstanding reaches FIFO_DEPTH. src_data, src_valid and src_last stay stable while valid & !ready.
- done: exactly one cycle wide. A new start is accepted in the cycle done is high (state is already IDLE).

## Configuration
- MP3_PC_RAM_READER_BSWAP_EN:
  - Defined: each word is byte-reversed on FIFO write, {b0,b1,b2,b3}. This gives big-endian MP3 bitstream order.
  - Undefined: data passes unchanged. No other behaviour differs.

## Test plan
- Reset, then start with start_addr=0x010 and word_count=8, src_ready=1. Required: reads go to 0x010..0x017 on consecutive cycles; 8 beats out in order; src_last on beat 8; done at E0+11.
- start_addr=0xFFE, word_count=4. Required: addresses 0xFFE, 0xFFF, 0x000, 0x001.
- word_count=16, src_ready toggling in a 1-on/3-off pattern. Required: no lost or duplicated words; avm_read never leaves more than FIFO_DEPTH words unconsumed.
- word_count=0. Required: done one cycle after start, busy never rises, avm_read stays 0.
- abort on the third beat of a 10-word transfer. Required: next cycle src_valid=0, busy=0, no done. A following start of 2 words delivers exactly 2 beats from the new address.
- RAM word 0x11223344 with the macro defined. Required: src_data=0x44332211. Without the macro: 0x11223344.

Source files
------------

// File: rtl/mp3_pc_ram_reader.sv
// Avalon-MM block reader from program RAM into an Avalon-ST source via a show-ahead FIFO.
// Optional byte reversal on FIFO write: define MP3_PC_RAM_READER_BSWAP_EN.
module mp3_pc_ram_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [11:0] start_addr,
    input  logic [12:0] word_count,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [11:0] avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic [31:0] src_data,
    output logic        src_valid,
    input  logic        src_ready,
    output logic        src_last
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [12:0]   count;
    logic [12:0]   issued;
    logic [12:0]   ret_idx;
    logic          rd_pend;
    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   level;
    logic          pop;
    logic          push;
    logic          ret_last;
    logic [31:0]   wr_data;

`ifdef MP3_PC_RAM_READER_BSWAP_EN
    assign wr_data = {avm_readdata[7:0], avm_readdata[15:8],
                      avm_readdata[23:16], avm_readdata[31:24]};
`else
    assign wr_data = avm_readdata;
`endif

    assign busy      = (state != S_IDLE);
    assign src_valid = (fifo_cnt != '0);
    assign src_data  = src_valid ? mem[rd_ptr][31:0] : 32'd0;
    assign src_last  = src_valid & mem[rd_ptr][32];
    assign pop       = src_valid & src_ready;
    assign push      = rd_pend & ~abort;
    assign ret_last  = (ret_idx == count - 13'd1);

    // Words already committed to the FIFO after this cycle, counting a return in flight.
    assign level = {1'b0, fifo_cnt} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, rd_pend};

    assign avm_read = (state == S_READ) && !abort
                   && (issued < count) && (level < DEPTH_V);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ret_last, wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            count       <= '0;
            issued      <= '0;
            ret_idx     <= '0;
            rd_pend     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            avm_address <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state    <= S_IDLE;
                rd_pend  <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else begin
                rd_pend <= avm_read;
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    ret_idx <= ret_idx + 13'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    fifo_cnt <= fifo_cnt + 1'b1;
                end else if (!push && pop) begin
                    fifo_cnt <= fifo_cnt - 1'b1;
                end
                if (avm_read) begin
                    avm_address <= avm_address + 12'd1;
                    issued      <= issued + 13'd1;
                end
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (word_count == 13'd0) begin
                                done <= 1'b1;
                            end else begin
                                state       <= S_READ;
                                count       <= word_count;
                                issued      <= '0;
                                ret_idx     <= '0;
                                avm_address <= start_addr;
                            end
                        end
                    end
                    S_READ: begin
                        if (avm_read && (issued == count - 13'd1)) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if ((fifo_cnt == {{AW{1'b0}}, pop}) && !rd_pend) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mp3_pc_ram_reader.sv
// Directed bench for mp3_pc_ram_reader with a one-cycle-latency RAM model.
// Honours MP3_PC_RAM_READER_BSWAP_EN when computing expected stream data.
module tb_mp3_pc_ram_reader;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] start_addr = '0;
    logic [12:0] word_count = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready = 1'b1;
    logic        src_last;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int e0 = 0;
    int ready_mode = 0;
    logic ready_fix = 1'b1;

    logic [32:0] bq[$];
    logic [11:0] aq[$];
    int done_cnt, done_cyc, first_vcyc;
    int rd_tot, pop_tot, max_unc, stab_err;
    logic prev_stall;
    logic [31:0] prev_data;
    logic prev_last;

    mp3_pc_ram_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .start(start), .start_addr(start_addr), .word_count(word_count),
        .abort(abort), .busy(busy), .done(done),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .src_last(src_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [11:0] a);
        return (a == 12'h123) ? 32'h1122_3344 : {20'hCAFE0, a};
    endfunction

    function automatic logic [31:0] exp_word(input logic [11:0] a);
        logic [31:0] w;
        w = ram_word(a);
`ifdef MP3_PC_RAM_READER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_read) avm_readdata <= ram_word(avm_address);
    end

    always @(posedge clk) begin
        #1;
        src_ready = (ready_mode != 0) ? (cyc % 4 == 0) : ready_fix;
    end

    always @(negedge clk) begin
        if (avm_read) begin
            aq.push_back(avm_address);
            rd_tot++;
        end
        if (src_valid && src_ready) begin
            bq.push_back({src_last, src_data});
            pop_tot++;
        end
        if (rd_tot - pop_tot > max_unc) max_unc = rd_tot - pop_tot;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (src_valid && first_vcyc < 0) first_vcyc = cyc;
        if (prev_stall && (!src_valid || src_data != prev_data
                           || src_last != prev_last))
            stab_err++;
        prev_stall = src_valid && !src_ready;
        prev_data  = src_data;
        prev_last  = src_last;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        bq.delete();
        aq.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_vcyc = -1;
        rd_tot = 0;
        pop_tot = 0;
        max_unc = 0;
        stab_err = 0;
        prev_stall = 1'b0;
    endtask

    task automatic do_start(input logic [11:0] a, input logic [12:0] n);
        @(posedge clk);
        #2;
        start = 1'b1;
        start_addr = a;
        word_count = n;
        @(posedge clk);
        #2;
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_seen", done_cnt, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input logic [11:0] base,
                                input int n);
        logic [11:0] a;
        chk({tag, "_reads"}, aq.size(), n);
        chk({tag, "_beats"}, bq.size(), n);
        for (int i = 0; i < n; i++) begin
            a = base + i[11:0];
            if (i < aq.size()) chk({tag, "_addr"}, {20'd0, aq[i]}, {20'd0, a});
            if (i < bq.size()) begin
                chk({tag, "_data"}, bq[i][31:0], exp_word(a));
                chk({tag, "_last"}, {31'd0, bq[i][32]},
                    {31'd0, (i == n - 1)});
            end
        end
    endtask

    initial begin
        clear_mon();
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_read", {31'd0, avm_read}, 0);
        chk("rst_addr", {20'd0, avm_address}, 0);
        chk("rst_valid", {31'd0, src_valid}, 0);
        chk("rst_data", src_data, 0);
        chk("rst_last", {31'd0, src_last}, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // 8 words, ready always high
        clear_mon();
        do_start(12'h010, 13'd8);
        @(negedge clk);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_read", {31'd0, avm_read}, 1);
        chk("t1_addr0", {20'd0, avm_address}, 32'h010);
        wait_done(40);
        chk("t1_first_valid", first_vcyc - e0, 2);
        chk("t1_done_cyc", done_cyc - e0, 10);
        chk("t1_done_once", done_cnt, 1);
        chk("t1_busy_after", {31'd0, busy}, 0);
        check_stream("t1", 12'h010, 8);

        // address wrap
        clear_mon();
        do_start(12'hFFE, 13'd4);
        wait_done(40);
        check_stream("t2", 12'hFFE, 4);

        // backpressure 1-on/3-off
        clear_mon();
        ready_mode = 1;
        do_start(12'h100, 13'd16);
        wait_done(200);
        ready_mode = 0;
        check_stream("t3", 12'h100, 16);
        chk("t3_unconsumed_ok", {31'd0, max_unc <= DEPTH}, 1);
        chk("t3_stable", stab_err, 0);

        // zero-length transfer
        clear_mon();
        do_start(12'h050, 13'd0);
        @(negedge clk);
        chk("t4_done", {31'd0, done}, 1);
        chk("t4_busy", {31'd0, busy}, 0);
        chk("t4_read", {31'd0, avm_read}, 0);
        @(negedge clk);
        chk("t4_done_width", {31'd0, done}, 0);
        chk("t4_busy2", {31'd0, busy}, 0);
        repeat (3) @(negedge clk);
        chk("t4_no_reads", aq.size(), 0);
        chk("t4_done_once", done_cnt, 1);

        // abort on third beat
        clear_mon();
        do_start(12'h200, 13'd10);
        begin
            int k;
            k = 0;
            while (k < 40 && !(bq.size() == 2 && src_valid)) begin
                @(posedge clk);
                #2;
                k++;
            end
            chk("t5_reach_beat3", {31'd0, k < 40}, 1);
        end
        abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
        chk("t5_valid", {31'd0, src_valid}, 0);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_data", src_data, 0);
        repeat (6) @(negedge clk);
        chk("t5_no_done", done_cnt, 0);
        chk("t5_idle_read", {31'd0, avm_read}, 0);
        clear_mon();
        do_start(12'h300, 13'd2);
        wait_done(40);
        check_stream("t5b", 12'h300, 2);

        // byte order of a known RAM word
        clear_mon();
        do_start(12'h123, 13'd1);
        wait_done(40);
        chk("t6_beats", bq.size(), 1);
        if (bq.size() > 0) begin
`ifdef MP3_PC_RAM_READER_BSWAP_EN
            chk("t6_data", bq[0][31:0], 32'h4433_2211);
`else
            chk("t6_data", bq[0][31:0], 32'h1122_3344);
`endif
            chk("t6_last", {31'd0, bq[0][32]}, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
